// File: rtl/match_ctrl.sv
// Match controller: serve/rally/point/over sequencing, scoring, pause and physics-engine gating.
// Define MATCH_CTRL_DEUCE_EN to require a two-point lead to win (first to 15 always wins).
module match_ctrl #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_frame_tick,
  input  logic       i_start_btn,
  input  logic       i_pause_btn,
  input  logic       i_phys_game_over,
  input  logic [1:0] i_phys_winner,
  input  logic       i_phys_valid,
  output logic       o_phys_en,
  output logic       o_phys_rst_n,
  output logic [3:0] o_p1_score,
  output logic [3:0] o_p2_score,
  output logic [2:0] o_state,
  output logic [1:0] o_match_winner,
  output logic       o_paused
);

  localparam int unsigned MaxFrames = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int unsigned CntW      = (MaxFrames < 1) ? 1 : $clog2(MaxFrames + 1);
  localparam logic [CntW-1:0] ServeLoad = CntW'(SERVE_FRAMES);
  localparam logic [CntW-1:0] PointLoad = CntW'(POINT_FRAMES);
  localparam logic [3:0]      WinScore  = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StRally = 3'd2,
    StPoint = 3'd3,
    StOver  = 3'd4
  } state_e;

  state_e          r_state, w_state_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [3:0]      r_p1, w_p1_d, r_p2, w_p2_d;
  logic [1:0]      r_winner, w_winner_d;
  logic            r_paused, w_paused_d;
  logic            r_phys_en, w_phys_en_d;
  logic            r_phys_rst_n, w_phys_rst_n_d;
  logic            r_start_prev, r_pause_prev;

  logic w_start_rise, w_pause_rise, w_count_done, w_tick_en;
  logic w_p1_wins, w_p2_wins;

  assign w_start_rise = i_start_btn & ~r_start_prev;
  assign w_pause_rise = i_pause_btn & ~r_pause_prev;
  assign w_count_done = (r_cnt == '0) && !r_paused;
  assign w_tick_en    = i_frame_tick && !r_paused;

`ifdef MATCH_CTRL_DEUCE_EN
  assign w_p1_wins = ((r_p1 >= WinScore) && ({1'b0, r_p1} >= {1'b0, r_p2} + 5'd2)) ||
                     ((r_p1 == 4'd15) && (r_p2 != 4'd15));
  assign w_p2_wins = ((r_p2 >= WinScore) && ({1'b0, r_p2} >= {1'b0, r_p1} + 5'd2)) ||
                     ((r_p2 == 4'd15) && (r_p1 != 4'd15));
`else
  assign w_p1_wins = (r_p1 >= WinScore);
  assign w_p2_wins = (r_p2 >= WinScore);
`endif

  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_p1_d         = r_p1;
    w_p2_d         = r_p2;
    w_winner_d     = r_winner;
    w_paused_d     = r_paused;
    w_phys_en_d    = 1'b0;
    w_phys_rst_n_d = 1'b1;

    if (w_pause_rise && (r_state == StServe || r_state == StRally || r_state == StPoint)) begin
      w_paused_d = ~r_paused;
    end

    unique case (r_state)
      StIdle, StOver: begin
        if (w_start_rise) begin
          w_state_d      = StServe;
          w_cnt_d        = ServeLoad;
          w_p1_d         = 4'd0;
          w_p2_d         = 4'd0;
          w_winner_d     = 2'd0;
          w_paused_d     = 1'b0;
          w_phys_rst_n_d = 1'b0;
        end
      end
      StServe: begin
        if (w_count_done) begin
          w_state_d = StRally;
        end else if (w_tick_en) begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      StRally: begin
        if (i_phys_valid && i_phys_game_over) begin
          w_state_d = StPoint;
          w_cnt_d   = PointLoad;
          if (i_phys_winner == 2'd1 && r_p1 != 4'd15) w_p1_d = r_p1 + 4'd1;
          if (i_phys_winner == 2'd2 && r_p2 != 4'd15) w_p2_d = r_p2 + 4'd1;
        end else if (i_frame_tick && !w_paused_d) begin
          // Pulse lands the cycle after the tick, gated by the pause state it will be seen with.
          w_phys_en_d = 1'b1;
        end
      end
      StPoint: begin
        if (w_count_done) begin
          if (w_p1_wins || w_p2_wins) begin
            w_state_d  = StOver;
            w_winner_d = w_p1_wins ? 2'd1 : 2'd2;
            w_paused_d = 1'b0;
          end else begin
            w_state_d      = StServe;
            w_cnt_d        = ServeLoad;
            w_phys_rst_n_d = 1'b0;
          end
        end else if (w_tick_en) begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Button history resets high so a button held through reset never reads as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_p1         <= 4'd0;
      r_p2         <= 4'd0;
      r_winner     <= 2'd0;
      r_paused     <= 1'b0;
      r_phys_en    <= 1'b0;
      r_phys_rst_n <= 1'b0;
      r_start_prev <= 1'b1;
      r_pause_prev <= 1'b1;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_p1         <= w_p1_d;
      r_p2         <= w_p2_d;
      r_winner     <= w_winner_d;
      r_paused     <= w_paused_d;
      r_phys_en    <= w_phys_en_d;
      r_phys_rst_n <= w_phys_rst_n_d;
      r_start_prev <= i_start_btn;
      r_pause_prev <= i_pause_btn;
    end
  end

  assign o_state        = r_state;
  assign o_p1_score     = r_p1;
  assign o_p2_score     = r_p2;
  assign o_match_winner = r_winner;
  assign o_paused       = r_paused;
  assign o_phys_en      = r_phys_en;
  assign o_phys_rst_n   = r_phys_rst_n;

endmodule

// File: tb/tb_match_ctrl.sv
// Randomized bench for match_ctrl against a point-level model of the match rules.
// Deuce scenarios are exercised when MATCH_CTRL_DEUCE_EN is defined.
module tb_match_ctrl;

  localparam int WIN   = 7;
  localparam int SERVE = 60;
  localparam int POINT = 90;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_RALLY = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0, start_btn = 1'b0, pause_btn = 1'b0;
  logic       phys_game_over = 1'b0, phys_valid = 1'b0;
  logic [1:0] phys_winner = 2'd0;
  logic       phys_en, phys_rst_n, paused;
  logic [3:0] p1_score, p2_score;
  logic [2:0] state;
  logic [1:0] match_winner;

  int checks = 0;
  int failures = 0;
  int m_p1 = 0;
  int m_p2 = 0;

  match_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SERVE), .POINT_FRAMES(POINT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_frame_tick    (frame_tick),
    .i_start_btn     (start_btn),
    .i_pause_btn     (pause_btn),
    .i_phys_game_over(phys_game_over),
    .i_phys_winner   (phys_winner),
    .i_phys_valid    (phys_valid),
    .o_phys_en       (phys_en),
    .o_phys_rst_n    (phys_rst_n),
    .o_p1_score      (p1_score),
    .o_p2_score      (p2_score),
    .o_state         (state),
    .o_match_winner  (match_winner),
    .o_paused        (paused)
  );

  always #5 clk = ~clk;

  // Match rules: who (if anyone) has won with the given scores.
  function automatic int model_winner(input int a, input int b);
`ifdef MATCH_CTRL_DEUCE_EN
    if ((a >= WIN && a - b >= 2) || (a == 15 && b < 15)) return 1;
    if ((b >= WIN && b - a >= 2) || (b == 15 && a < 15)) return 2;
    return 0;
`else
    if (a >= WIN) return 1;
    if (b >= WIN) return 2;
    return 0;
`endif
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) step();
  endtask

  task automatic press_pause();
    pause_btn = 1'b1;
    step();
    pause_btn = 1'b0;
    step();
  endtask

  task automatic press_start(input bit with_tick);
    start_btn  = 1'b1;
    frame_tick = with_tick;
    step();
    frame_tick = 1'b0;
    m_p1 = 0;
    m_p2 = 0;
    checks++;
    if ({state, phys_rst_n, p1_score, p2_score, match_winner} !== {ST_SERVE, 1'b0, 10'd0}) begin
      failures++;
      $display("FAIL start_entry: got st=%0d rstn=%0b p1=%0d p2=%0d win=%0d want st=1 rstn=0 rest 0",
               state, phys_rst_n, p1_score, p2_score, match_winner);
    end
    start_btn = 1'b0;
    step();
    checks++;
    if (phys_rst_n !== 1'b1) begin
      failures++;
      $display("FAIL start_rstn_pulse: got %0b want 1", phys_rst_n);
    end
  endtask

  // Count `frames` ticks in cur_st (optionally pausing 10 ticks before tick pause_at),
  // then expect exactly one more cycle to move to next_st.
  task automatic run_counter(input logic [2:0] cur_st, input logic [2:0] next_st,
                             input int frames, input int pause_at);
    bit coinc;
    for (int i = 1; i <= frames; i++) begin
      if (i == pause_at) begin
        press_pause();
        checks++;
        if (paused !== 1'b1) begin
          failures++;
          $display("FAIL pause_set st=%0d: got %0b want 1", cur_st, paused);
        end
        for (int k = 0; k < 10; k++) begin
          tick();
          checks++;
          if (phys_en !== 1'b0 || state !== cur_st) begin
            failures++;
            $display("FAIL paused_hold: got en=%0b st=%0d want en=0 st=%0d", phys_en, state, cur_st);
          end
          gap();
        end
        press_pause();
        checks++;
        if (paused !== 1'b0) begin
          failures++;
          $display("FAIL pause_clear st=%0d: got %0b want 0", cur_st, paused);
        end
      end
      tick();
      checks++;
      if (phys_en !== 1'b0) begin
        failures++;
        $display("FAIL en_outside_rally st=%0d tick=%0d: got %0b want 0", cur_st, i, phys_en);
      end
      if (i < frames) gap();
    end
    checks++;
    if (state !== cur_st) begin
      failures++;
      $display("FAIL count_early: got st=%0d want %0d", state, cur_st);
    end
    coinc = 1'($urandom_range(0, 1));
    frame_tick = coinc;
    step();
    frame_tick = 1'b0;
    checks++;
    if ({state, phys_en, phys_rst_n} !== {next_st, 1'b0, (next_st != ST_SERVE)}) begin
      failures++;
      $display("FAIL count_exit: got st=%0d en=%0b rstn=%0b want st=%0d en=0 rstn=%0b",
               state, phys_en, phys_rst_n, next_st, (next_st != ST_SERVE));
    end
    step();
    checks++;
    if (phys_rst_n !== 1'b1) begin
      failures++;
      $display("FAIL rstn_one_cycle: got %0b want 1", phys_rst_n);
    end
  endtask

  task automatic run_rally(input logic [1:0] code, input bit do_pause);
    int  n;
    bit  coinc;
    n = $urandom_range(1, 4);
    for (int k = 0; k < n; k++) begin
      tick();
      checks++;
      if (phys_en !== 1'b1 || state !== ST_RALLY) begin
        failures++;
        $display("FAIL rally_en: got en=%0b st=%0d want en=1 st=2", phys_en, state);
      end
      step();
      checks++;
      if (phys_en !== 1'b0) begin
        failures++;
        $display("FAIL rally_en_width: got %0b want 0", phys_en);
      end
      gap();
    end
    if (do_pause) begin
      press_pause();
      for (int k = 0; k < 10; k++) begin
        tick();
        checks++;
        if (phys_en !== 1'b0) begin
          failures++;
          $display("FAIL rally_paused_en: got %0b want 0", phys_en);
        end
        step();
        gap();
      end
      press_pause();
      tick();
      checks++;
      if (phys_en !== 1'b1) begin
        failures++;
        $display("FAIL rally_resume_en: got %0b want 1", phys_en);
      end
      step();
    end
    phys_valid  = 1'b1;
    phys_winner = code;
    step();
    phys_valid = 1'b0;
    checks++;
    if (state !== ST_RALLY) begin
      failures++;
      $display("FAIL valid_no_gameover: got st=%0d want 2", state);
    end
    coinc = 1'($urandom_range(0, 1));
    phys_valid     = 1'b1;
    phys_game_over = 1'b1;
    frame_tick     = coinc;
    step();
    {phys_valid, phys_game_over, frame_tick} = 3'b000;
    if (code == 2'd1) m_p1 = (m_p1 < 15) ? m_p1 + 1 : 15;
    if (code == 2'd2) m_p2 = (m_p2 < 15) ? m_p2 + 1 : 15;
    checks++;
    if ({state, phys_en, p1_score, p2_score} !== {ST_POINT, 1'b0, 4'(m_p1), 4'(m_p2)}) begin
      failures++;
      $display("FAIL point_entry code=%0d: got st=%0d en=%0b %0d-%0d want st=3 en=0 %0d-%0d",
               code, state, phys_en, p1_score, p2_score, m_p1, m_p2);
    end
    phys_valid     = 1'b1;
    phys_game_over = 1'b1;
    phys_winner    = 2'($urandom_range(1, 2));
    step();
    {phys_valid, phys_game_over} = 2'b00;
    checks++;
    if ({state, p1_score, p2_score} !== {ST_POINT, 4'(m_p1), 4'(m_p2)}) begin
      failures++;
      $display("FAIL repeat_strobe: got st=%0d %0d-%0d want st=3 %0d-%0d",
               state, p1_score, p2_score, m_p1, m_p2);
    end
  endtask

  task automatic play_point(input logic [1:0] code, input logic [2:0] pmask, output int w);
    run_counter(ST_SERVE, ST_RALLY, SERVE, pmask[0] ? $urandom_range(1, SERVE) : 0);
    run_rally(code, pmask[1]);
    w = model_winner(m_p1, m_p2);
    run_counter(ST_POINT, (w != 0) ? ST_OVER : ST_SERVE, POINT,
                pmask[2] ? $urandom_range(1, POINT) : 0);
    if (w != 0) begin
      checks++;
      if ({match_winner, paused} !== {2'(w), 1'b0}) begin
        failures++;
        $display("FAIL over_winner: got win=%0d paused=%0b want win=%0d paused=0",
                 match_winner, paused, w);
      end
    end
  endtask

  task automatic test_reset();
    start_btn = 1'b1;
    pause_btn = 1'b1;
    step();
    step();
    checks++;
    if ({state, p1_score, p2_score, match_winner, paused, phys_en, phys_rst_n} !== 16'h0) begin
      failures++;
      $display("FAIL reset_values: got st=%0d %0d-%0d win=%0d p=%0b en=%0b rstn=%0b want all 0",
               state, p1_score, p2_score, match_winner, paused, phys_en, phys_rst_n);
    end
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if ({state, phys_rst_n, paused} !== {ST_IDLE, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL held_buttons: got st=%0d rstn=%0b p=%0b want st=0 rstn=1 p=0",
               state, phys_rst_n, paused);
    end
    {start_btn, pause_btn} = 2'b00;
    step();
    press_pause();
    checks++;
    if (paused !== 1'b0) begin
      failures++;
      $display("FAIL idle_pause: got %0b want 0", paused);
    end
  endtask

  task automatic test_first_point();
    int w;
    press_start(1'b1);
    play_point(2'd2, 3'b000, w);
    play_point(($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0, 3'b111, w);
  endtask

  task automatic test_reset_mid_point();
    run_counter(ST_SERVE, ST_RALLY, SERVE, 0);
    run_rally(2'd1, 1'b0);
    repeat (5) begin
      tick();
      gap();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state, p1_score, p2_score, match_winner, paused, phys_en, phys_rst_n} !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid_point: got st=%0d %0d-%0d win=%0d p=%0b en=%0b rstn=%0b want 0",
               state, p1_score, p2_score, match_winner, paused, phys_en, phys_rst_n);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({state, phys_rst_n} !== {ST_IDLE, 1'b1}) begin
      failures++;
      $display("FAIL after_reset: got st=%0d rstn=%0b want st=0 rstn=1", state, phys_rst_n);
    end
  endtask

  task automatic test_reset_mid_rally();
    press_start(1'b0);
    run_counter(ST_SERVE, ST_RALLY, SERVE, 0);
    tick();
    step();
    phys_valid     = 1'b1;
    phys_game_over = 1'b1;
    phys_winner    = 2'd1;
    rst_n          = 1'b0;
    step();
    {phys_valid, phys_game_over} = 2'b00;
    rst_n = 1'b1;
    step();
    m_p1 = 0;
    m_p2 = 0;
    checks++;
    if ({state, p1_score, p2_score} !== {ST_IDLE, 8'd0}) begin
      failures++;
      $display("FAIL reset_mid_rally: got st=%0d %0d-%0d want st=0 0-0", state, p1_score, p2_score);
    end
  endtask

  task automatic test_match_p1();
    int w = 0;
    int n = 0;
    logic [1:0] code;
    press_start(1'($urandom_range(0, 1)));
    while (w == 0 && n < 30) begin
      case ($urandom_range(0, 4))
        0:       code = 2'd0;
        1:       code = 2'd3;
        default: code = 2'd1;
      endcase
      play_point(code, 3'($urandom_range(0, 7)), w);
      n++;
    end
    checks++;
    if ({state, match_winner, p1_score, p2_score} !== {ST_OVER, 2'd1, 4'(WIN), 4'd0}) begin
      failures++;
      $display("FAIL p1_match: got st=%0d win=%0d %0d-%0d want st=4 win=1 %0d-0",
               state, match_winner, p1_score, p2_score, WIN);
    end
  endtask

  task automatic test_restart();
    press_pause();
    checks++;
    if ({state, paused} !== {ST_OVER, 1'b0}) begin
      failures++;
      $display("FAIL over_pause: got st=%0d p=%0b want st=4 p=0", state, paused);
    end
    press_start(1'b0);
  endtask

  task automatic test_random_match();
    int w = 0;
    int n = 0;
    while (w == 0 && n < 40) begin
      play_point(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), w);
      n++;
    end
    checks++;
    if (state !== ((w != 0) ? ST_OVER : ST_SERVE)) begin
      failures++;
      $display("FAIL random_match_end: got st=%0d want %0d", state, (w != 0) ? 4 : 1);
    end
  endtask

`ifdef MATCH_CTRL_DEUCE_EN
  task automatic test_deuce();
    int w;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    press_start(1'b0);
    for (int i = 0; i < 6; i++) begin
      play_point(2'd1, 3'b000, w);
      play_point(2'd2, 3'b000, w);
    end
    play_point(2'd1, 3'b000, w);
    checks++;
    if ({state, p1_score, p2_score} !== {ST_SERVE, 4'd7, 4'd6}) begin
      failures++;
      $display("FAIL deuce_7_6: got st=%0d %0d-%0d want st=1 7-6", state, p1_score, p2_score);
    end
    play_point(2'd1, 3'b000, w);
    checks++;
    if ({state, match_winner} !== {ST_OVER, 2'd1}) begin
      failures++;
      $display("FAIL deuce_8_6: got st=%0d win=%0d want st=4 win=1", state, match_winner);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_point();
    test_reset_mid_point();
    test_reset_mid_rally();
    test_match_p1();
    test_restart();
    test_random_match();
`ifdef MATCH_CTRL_DEUCE_EN
    test_deuce();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
